// File: rtl/stump_mem_seq_if.sv
// Memory-side bus between the Stump access sequencer (master) and external memory (slave).
interface stump_mem_seq_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] data_in;
    logic              mem_ack;

    modport master (
        output address, data_out, mem_ren, mem_wen,
        input  data_in, mem_ack
    );

    modport slave (
        input  address, data_out, mem_ren, mem_wen,
        output data_in, mem_ack
    );
endinterface

// File: rtl/stump_mem_seq.sv
// Memory-access sequencer for the Stump core: registered strobes, ack or fixed-wait completion,
// access timeout with sticky error, and a core stall while an access is outstanding.
module stump_mem_seq #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned WAIT_MODE = 0,
    parameter int unsigned WAIT_CYC  = 2,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic              err_sticky,
    input  logic              err_clr,
    stump_mem_seq_if.master   mem
);

    localparam int unsigned CntMax = (TIMEOUT > WAIT_CYC) ? TIMEOUT : WAIT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] WaitLast    = CntW'(WAIT_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic            is_write;
    logic            acc_done;
    logic            acc_timeout;

    always_comb begin
        core_stall = 1'b0;
        unique case (state)
            StIdle:   core_stall = cpu_ren | cpu_wen;
            StAccess: core_stall = 1'b1;
            default:  core_stall = 1'b0;
        endcase
    end

    // Ack beats a timeout that lands in the same cycle.
    always_comb begin
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        if (WAIT_MODE == 0) begin
            if (mem.mem_ack) begin
                acc_done = 1'b1;
            end else if (cnt == TimeoutLast) begin
                acc_done    = 1'b1;
                acc_timeout = 1'b1;
            end
        end else if (cnt == WaitLast) begin
            acc_done = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            cnt          <= '0;
            is_write     <= 1'b0;
            rd_data      <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            err_sticky   <= 1'b0;
            mem.address  <= '0;
            mem.data_out <= '0;
            mem.mem_ren  <= 1'b0;
            mem.mem_wen  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                err_sticky <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (cpu_ren || cpu_wen) begin
                        mem.address <= cpu_addr;
                        if (cpu_wen) begin
                            mem.data_out <= cpu_wdata;
                        end
                        is_write    <= cpu_wen;
                        mem.mem_wen <= cpu_wen;
                        mem.mem_ren <= ~cpu_wen;
                        cnt         <= '0;
                        state       <= StAccess;
                    end
                end
                StAccess: begin
                    if (acc_done) begin
                        mem.mem_ren <= 1'b0;
                        mem.mem_wen <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_err    <= acc_timeout;
                        if (acc_timeout) begin
                            err_sticky <= 1'b1;
                        end
                        if (!is_write) begin
                            rd_data <= acc_timeout ? '0 : mem.data_in;
                        end
                        state <= StResp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/stump_mem_seq.md
Name: stump_mem_seq

Overview:
- Parametrised memory-access sequencer between the Stump core and a variable-latency memory.
- Replaces the single-cycle memory assumption with a registered request/acknowledge handshake, a fixed-wait-state mode, a timeout, and a stall signal that freezes the core's fetch/execute/memory sequencing.
- Sits between the core's memory request signals and the external address/data/strobe pins.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 16, address bus width.
- WAIT_MODE, 0, 0 = complete on mem_ack; 1 = complete after WAIT_CYC wait cycles, mem_ack ignored.
- WAIT_CYC, 2, wait states in mode 1 (0 legal).
- TIMEOUT, 15, ACCESS cycles without ack (mode 0) before an error response; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low (0 = reset).
- cpu_ren  in  1  core read request.
- cpu_wen  in  1  core write request; has priority over cpu_ren.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- core_stall  out  1  core must hold its state and request.
- rd_data  out  DATA_W  captured read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  one-cycle pulse: access timed out.
- err_sticky  out  1  set on any timeout; cleared by err_clr.
- err_clr  in  1  clears err_sticky.
- address  out  ADDR_W  memory address (registered).
- data_out  out  DATA_W  memory write data (registered).
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- data_in  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion (mode 0).

Behaviour:
- States: IDLE, ACCESS, RESP. Wait counter width is clog2(max(TIMEOUT, WAIT_CYC) + 1).
- Reset (rst = 0, asynchronous, including mid-access):
  - state = IDLE; counter = 0.
  - All outputs = 0: address, data_out, rd_data, strobes, resp_valid, resp_err, err_sticky.
- core_stall is combinational:
  - 1 in IDLE when (cpu_ren | cpu_wen);
  - 1 in ACCESS;
  - 0 in RESP.
- IDLE:
  - On cpu_ren | cpu_wen: latch cpu_addr into address and cpu_wdata into data_out (write only); latch type; counter = 0; go to ACCESS.
  - When cpu_wen = 1, the write is performed even if cpu_ren is also 1.
- ACCESS:
  - Strobes are registered: mem_wen = 1 for a write, mem_ren = 1 for a read; exactly one strobe is high, for the whole state.
  - address and data_out are stable for the whole state.
  - Mode 0:
    - mem_ack = 1: capture data_in into rd_data (reads only; rd_data unchanged on writes) and go to RESP.
    - Otherwise, if counter == TIMEOUT - 1: go to RESP with an error, rd_data = 0 on reads.
    - Otherwise counter increments.
    - mem_ack and timeout in the same cycle: ack wins, no error.
  - Mode 1:
    - When counter == WAIT_CYC: capture data_in (reads) and go to RESP.
    - Otherwise counter increments.
- RESP (one cycle):
  - Strobes = 0.
  - resp_valid = 1; resp_err = 1 if the access timed out; err_sticky set on timeout.
  - The core advances this cycle; cpu_ren/cpu_wen seen in RESP are ignored.
  - Next state is always IDLE.
- Latency (request-cycle to resp_valid):
  - Mode 0, ack in ACCESS cycle k (k = 1 first): k + 1 cycles; stall high for k + 1 cycles.
  - Mode 1: WAIT_CYC + 2 cycles; WAIT_CYC = 0 gives stall for 2 cycles.
  - Timeout: TIMEOUT + 1 cycles.
- Idle/error handling:
  - mem_ack outside ACCESS is ignored.
  - err_clr has effect in any state; if a timeout sets err_sticky in the same cycle as err_clr, set wins.
  - address and data_out hold their last values in IDLE and RESP.

Test Plan:
1. Reset mid-access: mode 0, read 0x0040 issued; drive rst = 0 during ACCESS -> all outputs 0 immediately, state IDLE. Release rst -> core_stall = 0 with no request.
2. Read with ack: mode 0; cpu_ren, cpu_addr = 0x1234; mem_ack in 3rd ACCESS cycle with data_in = 0xBEEF.
   - mem_ren high 3 cycles, address = 0x1234.
   - Then resp_valid = 1, rd_data = 0xBEEF; stall high 4 cycles.
3. Simultaneous requests: cpu_ren = cpu_wen = 1, addr = 0x0010, wdata = 0xA5A5 -> mem_wen = 1, mem_ren = 0, data_out = 0xA5A5, address = 0x0010.
4. Timeout: mode 0, TIMEOUT = 15, mem_ack never asserted.
   - mem_ren high 15 cycles, then resp_valid = resp_err = 1, rd_data = 0, err_sticky = 1.
   - err_clr pulse clears err_sticky.
   - Repeat with ack and timeout in the same cycle -> no error.
5. Fixed waits: mode 1, WAIT_CYC = 2, read 0x00FF with data_in = 0x0007 and mem_ack toggling -> mem_ren high 3 cycles, resp_valid on the 4th, rd_data = 0x0007. With WAIT_CYC = 0 -> strobe high 1 cycle.
6. Back-to-back: write 0x0001 <- 0x1111, request held through RESP, then read 0x0002 -> exactly one write and one read strobe burst, with one IDLE-or-request cycle between them; no duplicate write.
